// File: rtl/blink_sched.sv
// Round-robin scheduler handing four requesters timed slots on a shared blink counter.
// Define BLINK_SCHED_GAP_EN to insert one idle GAP cycle at every slot end.
module blink_sched #(
  parameter int SLOT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  req_i,
  input  logic [11:0] div_sel_i,
  output logic [3:0]  gnt_o,
  output logic        en_o,
  output logic        busy_o
);

  localparam int               CNT_W     = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

`ifdef BLINK_SCHED_GAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1} state_t;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_gnt;
  logic [1:0]       r_ptr;
  logic [2:0]       r_k;
  logic [7:0]       r_pre;
  logic [CNT_W-1:0] r_slot;

  logic       w_any_req;
  logic       w_held;
  logic       w_slot_end;
  logic       w_grant;
  logic [1:0] w_win;
  logic [7:0] w_mask;

  assign w_any_req  = |req_i;
  assign w_held     = |(r_gnt & req_i);
  assign w_slot_end = (r_state == S_RUN) && (!w_held || (r_slot == SLOT_LAST));
  assign w_mask     = (8'd1 << r_k) - 8'd1;

  // Scan downward so the lowest offset above ptr wins; offset 4 is the holder itself.
  always_comb begin
    w_win = r_ptr;
    for (int i = 4; i >= 1; i--) begin
      if (req_i[r_ptr + 2'(i)]) w_win = r_ptr + 2'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_next = S_RUN;
      S_RUN: begin
        if (w_slot_end) begin
`ifdef BLINK_SCHED_GAP_EN
          w_next = S_GAP;
`else
          w_next = w_any_req ? S_RUN : S_IDLE;
`endif
        end
      end
`ifdef BLINK_SCHED_GAP_EN
      S_GAP:   w_next = w_any_req ? S_RUN : S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    en_o   = 1'b0;
    busy_o = (r_state != S_IDLE);
    if ((r_state == S_RUN) && w_held && ((r_pre & w_mask) == 8'd0)) en_o = 1'b1;
  end

  // A new grant is taken on entry to RUN from anywhere except an ongoing slot.
  assign w_grant = (w_next == S_RUN) && !((r_state == S_RUN) && !w_slot_end);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_gnt  <= 4'd0;
      r_ptr  <= 2'd3;
      r_k    <= 3'd0;
      r_pre  <= 8'd0;
      r_slot <= '0;
    end else if (w_grant) begin
      r_gnt  <= 4'b0001 << w_win;
      r_ptr  <= w_win;
      r_k    <= div_sel_i[3*w_win +: 3];
      r_pre  <= 8'd0;
      r_slot <= '0;
    end else if (w_slot_end) begin
      r_gnt  <= 4'd0;
      r_pre  <= 8'd0;
      r_slot <= '0;
    end else if (r_state == S_RUN) begin
      r_pre  <= r_pre + 8'd1;
      r_slot <= r_slot + CNT_W'(1);
    end
  end

  assign gnt_o = r_gnt;

endmodule

// File: tb/tb_blink_sched.sv
// Table-driven bench for blink_sched with SLOT_CYCLES=8; adapts to BLINK_SCHED_GAP_EN.
module tb_blink_sched;

  localparam int SLOT = 8;
`ifdef BLINK_SCHED_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  typedef struct {
    bit         chk;
    bit         rst;
    logic [3:0] req;
    logic [11:0] div;
    logic [3:0] gnt;
    logic       en;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'd0;
  logic [11:0] div = 12'd0;
  logic [3:0]  gnt;
  logic        en;
  logic        busy;
  int          n_cmp = 0;
  int          n_bad = 0;

  blink_sched #(.SLOT_CYCLES(SLOT)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .div_sel_i(div),
    .gnt_o    (gnt),
    .en_o     (en),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit c, input bit r, input logic [3:0] q, input logic [11:0] d,
                              input logic [3:0] g, input logic e, input logic b);
    vecs.push_back('{c, r, q, d, g, e, b});
  endfunction

  // One full slot; pat bit c is the expected en_o on RUN cycle c.
  function automatic void slot(input logic [3:0] q, input logic [11:0] d, input logic [3:0] g,
                               input logic [7:0] pat);
    for (int c = 0; c < SLOT; c++) add(1, 0, q, d, g, pat[c], 1);
  endfunction

  function automatic void gap(input logic [3:0] q, input logic [11:0] d);
    if (GAP) add(1, 0, q, d, 4'd0, 1'b0, 1'b1);
  endfunction

  int cnt;
  int gaps;

  initial begin
    // reset
    add(0, 1, 4'h0, 12'h000, 4'h0, 0, 0);
    add(1, 1, 4'h0, 12'h000, 4'h0, 0, 0);
    // two requesters at full rate, back-to-back rotation
    add(1, 0, 4'b0101, 12'h000, 4'h0, 0, 0);
    slot(4'b0101, 12'h000, 4'b0001, 8'hFF); gap(4'b0101, 12'h000);
    slot(4'b0101, 12'h000, 4'b0100, 8'hFF); gap(4'b0101, 12'h000);
    add(1, 0, 4'b0101, 12'h000, 4'b0001, 1, 1);
    add(1, 0, 4'b0000, 12'h000, 4'b0001, 0, 1); gap(4'h0, 12'h000);
    add(1, 0, 4'b0000, 12'h000, 4'h0, 0, 0);
    add(1, 0, 4'b0000, 12'h000, 4'h0, 0, 0);
    // k0=2: en on cycles 0 and 4 of every slot
    add(1, 0, 4'b0001, 12'h002, 4'h0, 0, 0);
    slot(4'b0001, 12'h002, 4'b0001, 8'h11); gap(4'b0001, 12'h002);
    slot(4'b0001, 12'h002, 4'b0001, 8'h11); gap(4'b0001, 12'h002);
    add(1, 0, 4'b0000, 12'h002, 4'b0001, 0, 1); gap(4'h0, 12'h000);
    add(1, 0, 4'b0000, 12'h000, 4'h0, 0, 0);
    // early release at RUN cycle 3
    add(1, 0, 4'b0010, 12'h000, 4'h0, 0, 0);
    for (int c = 0; c < 3; c++) add(1, 0, 4'b0010, 12'h000, 4'b0010, 1, 1);
    add(1, 0, 4'b0000, 12'h000, 4'b0010, 0, 1); gap(4'h0, 12'h000);
    add(1, 0, 4'b0000, 12'h000, 4'h0, 0, 0);
    // reset mid-slot; ptr=1 so the pre-reset grant is 0100, post-reset grant 0001
    add(1, 0, 4'b1111, 12'h000, 4'h0, 0, 0);
    for (int c = 0; c < 4; c++) add(1, 0, 4'b1111, 12'h000, 4'b0100, 1, 1);
    add(1, 1, 4'b1111, 12'h000, 4'b0100, 1, 1);
    add(1, 0, 4'b1111, 12'h000, 4'h0, 0, 0);
    for (int c = 0; c < 3; c++) add(1, 0, 4'b1111, 12'h000, 4'b0001, 1, 1);
    add(1, 0, 4'b0000, 12'h000, 4'b0001, 0, 1); gap(4'h0, 12'h000);
    add(1, 0, 4'b0000, 12'h000, 4'h0, 0, 0);
    // k0=3 latched; switching div_sel to 0 mid-slot must not change spacing
    add(1, 0, 4'b0001, 12'h003, 4'h0, 0, 0);
    add(1, 0, 4'b0001, 12'h003, 4'b0001, 1, 1);
    add(1, 0, 4'b0001, 12'h003, 4'b0001, 0, 1);
    for (int c = 2; c < SLOT; c++) add(1, 0, 4'b0001, 12'h000, 4'b0001, 0, 1);
    gap(4'b0001, 12'h000);
    for (int c = 0; c < 3; c++) add(1, 0, 4'b0001, 12'h000, 4'b0001, 1, 1);
    add(1, 0, 4'b0000, 12'h000, 4'b0001, 0, 1); gap(4'h0, 12'h000);
    add(1, 0, 4'b0000, 12'h000, 4'h0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      rst = vecs[i].rst;
      req = vecs[i].req;
      div = vecs[i].div;
      @(negedge clk);
      if (vecs[i].chk) begin
        cmp($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
        cmp($sformatf("v%0d en", i), 32'(en), 32'(vecs[i].en));
        cmp($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      end
    end

    // Rotation 1 -> 3 with slot length and handover gap measured; ptr=0 here.
    @(posedge clk); #1;
    rst = 1'b0; req = 4'b1010; div = 12'h000;
    cnt = 0;
    while (gnt !== 4'b0010 && cnt < 4) begin @(posedge clk); #1; cnt++; end
    cmp("rr first grant", 32'(gnt), 32'(4'b0010));
    cnt = 0;
    while (gnt === 4'b0010 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    cmp("slot length", cnt, SLOT);
    gaps = 0;
    while (gnt === 4'b0000 && gaps < 4) begin @(posedge clk); #1; gaps++; end
    cmp("handover gap", gaps, GAP ? 1 : 0);
    cmp("rr second grant", 32'(gnt), 32'(4'b1000));
    req = 4'b0000;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 6) begin @(posedge clk); #1; cnt++; end
    cmp("release to idle", 32'(busy), 32'(0));
    cmp("idle gnt", 32'(gnt), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
